// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, opcode/funct
// constants, instruction classes and datapath mux/ALU select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE,
        C_JR,
        C_LW,
        C_SW,
        C_ADDI,
        C_ORI,
        C_BEQ,
        C_J,
        C_JAL,
        C_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [1:0] GPR_RD   = 2'd0;
    localparam logic [1:0] GPR_RT   = 2'd1;
    localparam logic [1:0] GPR_RA   = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MDR   = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;

    localparam logic [1:0] SRCB_RD2   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       ext_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] npc_op;
        logic [1:0] gpr_sel;
        logic [1:0] wd_sel;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction classifier: Op/Funct -> instruction class and ALU operation.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   Op,
    input  logic [5:0]   Funct,
    output instr_class_t cls,
    output logic [2:0]   alu_op
);

    always_comb begin
        cls    = C_ILLEGAL;
        alu_op = ALU_ADD;
        case (Op)
            OP_RTYPE: begin
                case (Funct)
                    FN_ADDU: begin cls = C_RTYPE; alu_op = ALU_ADD; end
                    FN_SUBU: begin cls = C_RTYPE; alu_op = ALU_SUB; end
                    FN_AND:  begin cls = C_RTYPE; alu_op = ALU_AND; end
                    FN_OR:   begin cls = C_RTYPE; alu_op = ALU_OR;  end
                    FN_SLT:  begin cls = C_RTYPE; alu_op = ALU_SLT; end
                    FN_JR:   cls = C_JR;
                    default: cls = C_ILLEGAL;
                endcase
            end
            OP_ADDI: begin cls = C_ADDI; alu_op = ALU_ADD; end
            OP_ORI:  begin cls = C_ORI;  alu_op = ALU_OR;  end
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  begin cls = C_BEQ;  alu_op = ALU_SUB; end
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM driving the shared memory and datapath muxes.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions trap to HALT and add a halted port.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       EXTOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       instr_done,
    output logic [3:0] state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       halted
`endif
);

    instr_class_t cls;
    logic [2:0]   dec_alu_op;
    state_t       state_q;
    state_t       state_n;
    ctrl_t        ctrl_q;

    mc_ctrl_dec u_dec (
        .Op     (Op),
        .Funct  (Funct),
        .cls    (cls),
        .alu_op (dec_alu_op)
    );

    // Moore decode, evaluated on the next state so the outputs can be registered.
    // Op/Funct come from the IR, which is stable from DECODE onward.
    function automatic ctrl_t moore_ctrl(input state_t s, input instr_class_t c,
                                         input logic [2:0] op);
        ctrl_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.mem_read  = 1'b1;
                o.alu_src_b = SRCB_FOUR;
                o.alu_op    = ALU_ADD;
                o.npc_op    = NPC_PC4;
            end
            S_DECODE: o.ext_op = 1'b1;
            S_MEMADR: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = ALU_ADD;
                o.ext_op    = 1'b1;
            end
            S_MEMRD: begin
                o.mem_read = 1'b1;
                o.iord     = 1'b1;
            end
            S_MEMWB: begin
                o.reg_write = 1'b1;
                o.gpr_sel   = GPR_RT;
                o.wd_sel    = WD_MDR;
                o.done      = 1'b1;
            end
            S_MEMWR: begin
                o.mem_write = 1'b1;
                o.iord      = 1'b1;
            end
            S_EXEC: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_RD2;
                o.alu_op    = op;
            end
            S_ALUWB: begin
                o.reg_write = 1'b1;
                o.gpr_sel   = GPR_RD;
                o.wd_sel    = WD_ALU;
                o.done      = 1'b1;
            end
            S_IEXEC: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = op;
                o.ext_op    = (c == C_ADDI);
            end
            S_IWB: begin
                o.reg_write = 1'b1;
                o.gpr_sel   = GPR_RT;
                o.wd_sel    = WD_ALU;
                o.done      = 1'b1;
            end
            S_BRANCH: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_RD2;
                o.alu_op    = ALU_SUB;
                o.npc_op    = NPC_BRANCH;
                o.done      = 1'b1;
            end
            S_JUMP: begin
                o.pc_write = 1'b1;
                o.done     = 1'b1;
                o.npc_op   = (c == C_JR) ? NPC_JR : NPC_JUMP;
                if (c == C_JAL) begin
                    o.reg_write = 1'b1;
                    o.gpr_sel   = GPR_RA;
                    o.wd_sel    = WD_PC;
                end
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_n = S_FETCH;
        case (state_q)
            S_FETCH:  state_n = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (cls)
                    C_LW, C_SW:     state_n = S_MEMADR;
                    C_RTYPE:        state_n = S_EXEC;
                    C_ADDI, C_ORI:  state_n = S_IEXEC;
                    C_BEQ:          state_n = S_BRANCH;
                    C_J, C_JAL, C_JR: state_n = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:        state_n = S_HALT;
`else
                    default:        state_n = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_n = (cls == C_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_n = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_n = S_FETCH;
            S_MEMWR:  state_n = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_n = S_ALUWB;
            S_ALUWB:  state_n = S_FETCH;
            S_IEXEC:  state_n = S_IWB;
            S_IWB:    state_n = S_FETCH;
            S_BRANCH: state_n = S_FETCH;
            S_JUMP:   state_n = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_HALT:   state_n = S_HALT;
`endif
            default:  state_n = S_FETCH;
        endcase
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic halted_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= state_t'(RESET_STATE);
            ctrl_q   <= moore_ctrl(state_t'(RESET_STATE), cls, dec_alu_op);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            ctrl_q   <= moore_ctrl(state_n, cls, dec_alu_op);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            halted_q <= (state_n == S_HALT);
`endif
        end
    end

    // Input-qualified terms stay combinational so they act in the same cycle.
    logic illegal_nop;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_nop = 1'b0;
    assign halted      = halted_q;
`else
    assign illegal_nop = (state_q == S_DECODE) && (cls == C_ILLEGAL);
`endif

    assign PCWrite    = ctrl_q.pc_write
                      | ((state_q == S_FETCH)  & mem_ready)
                      | ((state_q == S_BRANCH) & Zero);
    assign IRWrite    = (state_q == S_FETCH) & mem_ready;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = ctrl_q.mem_write;
    assign IorD       = ctrl_q.iord;
    assign RegWrite   = ctrl_q.reg_write;
    assign EXTOp      = ctrl_q.ext_op;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign ALUOp      = ctrl_q.alu_op;
    assign NPCOp      = ctrl_q.npc_op;
    assign GPRSel     = ctrl_q.gpr_sel;
    assign WDSel      = ctrl_q.wd_sel;
    assign instr_done = ctrl_q.done
                      | ((state_q == S_MEMWR) & mem_ready)
                      | illegal_nop;
    assign state      = state_q;

endmodule
